muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width; legal range 8..64.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port src_a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port src_b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port flush  input  1  abort any in-flight operation.
REQ-009 SHALL have ports wr_hi and wr_lo  input  1 each  MTHI/MTLO write strobes.
REQ-010 SHALL have port wr_data  input  WIDTH  MTHI/MTLO write data.
REQ-011 SHALL have port busy  output  1  operation in flight; pipeline stalls MFHI/MFLO on it.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.
REQ-014 SHALL have port div_by_zero  output  1  qualifies done for a zero divisor.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; IDLE->MUL/DIV on accepted start; MUL/DIV->DONE after WIDTH iteration cycles; DONE->IDLE, or DONE->MUL/DIV if start is present in DONE.
REQ-016 SHALL accept start in IDLE or DONE only; start in MUL/DIV SHALL be ignored.
REQ-017 SHALL register operands at the accepting edge; later src_a/src_b changes SHALL have no effect.
REQ-018 SHALL use a radix-2 iterative datapath, one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle.
REQ-019 SHALL hold busy high for exactly WIDTH cycles after the accepting edge, then drive done=1 for one cycle with busy=0.
REQ-020 SHALL update hi/lo in the same cycle done is asserted, and at no other time except MTHI/MTLO writes.
REQ-021 Multiply SHALL produce the full 2*WIDTH product: hi = upper half, lo = lower half.
REQ-022 Divide SHALL produce lo = quotient and hi = remainder.
REQ-023 Signed ops SHALL operate on magnitudes and correct signs in the final cycle: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-024 Signed MIN / -1 SHALL produce lo = MIN and hi = 0, with no flag.
REQ-025 A zero divisor SHALL bypass iteration: done follows the accepting edge by one cycle, lo = all ones, hi = dividend, div_by_zero = 1 in that done cycle.
REQ-026 flush SHALL return the FSM to IDLE on the next edge: no done, hi/lo unchanged; flush together with start SHALL drop the start.
REQ-027 wr_hi/wr_lo SHALL write hi/lo on the next edge only when the FSM is not in MUL/DIV; writes in MUL/DIV SHALL be ignored.
REQ-028 A write coincident with an accepted start SHALL take effect, and the later result SHALL overwrite it.

Reset
REQ-029 Reset low SHALL immediately force: FSM = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, internal accumulators = 0.
REQ-030 Reset mid-operation SHALL discard the operation; no done SHALL follow reset release.

Configuration
REQ-031 The divider SHALL be present only when macro MULDIV_DIV_EN is defined.
REQ-032 Without MULDIV_DIV_EN, DIVU/DIV SHALL be accepted, never assert busy, pulse done one cycle later with hi/lo unchanged and div_by_zero = 0, and no divider logic SHALL be synthesised.

Verification (WIDTH=32, MULDIV_DIV_EN defined unless stated)
REQ-033 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy 32 cycles; done on cycle 33; hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-034 MULT 0xFFFFFFFD (-3) * 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-036 DIVU 5 / 0 -> done next cycle with div_by_zero = 1; lo = 0xFFFFFFFF, hi = 5.
REQ-037 MULTU 3 * 4 with flush on cycle 10 -> busy = 0 on cycle 11; no done; hi/lo keep prior values; wr_lo 0x1234 during busy is ignored.
REQ-038 reset low on cycle 5 of DIVU -> hi/lo/busy/done = 0 at once; no done after release; without MULDIV_DIV_EN, DIVU 9 / 3 -> done after one cycle, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, HI/LO write and status bundle for muldiv_unit.
// master drives requests; slave is the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    output wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    input  wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO.
// Restoring divider is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [1:0]       sgn_q, sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               last, idle_like, accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    a_neg = bus.op[0] & bus.src_a[WIDTH-1];
    b_neg = bus.op[0] & bus.src_b[WIDTH-1];
    a_mag = a_neg ? -bus.src_a : bus.src_a;
    b_mag = b_neg ? -bus.src_b : bus.src_b;
    last  = (cnt_q == CW'(WIDTH-1));

    // product lives in {acc, q}; q shifts the multiplier out from bit 0
    mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    prod     = {mul_sum, q_q[WIDTH-1:1]};
    prod_fix = (sgn_q[1] ^ sgn_q[0]) ? -prod : prod;

`ifdef MULDIV_DIV_EN
    div_sh   = {acc_q, q_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = ~div_diff[WIDTH];
    quo      = {q_q[WIDTH-2:0], div_ok};
    rem      = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    quo_fix  = (sgn_q[1] ^ sgn_q[0]) ? -quo : quo;
    rem_fix  = sgn_q[1] ? -rem : rem;
`endif

    idle_like = (state_q == IDLE) || (state_q == DONE);
    accept    = idle_like & bus.start & ~bus.flush;

    if (idle_like) begin
      if (bus.wr_hi) hi_d = bus.wr_data;
      if (bus.wr_lo) lo_d = bus.wr_data;
    end

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            cnt_d = '0;
            acc_d = '0;
            sgn_d = {a_neg, b_neg};
            unique case (1'b1)
              !bus.op[1]: begin
                state_d = MUL;
                m_d     = a_mag;
                q_d     = b_mag;
              end
`ifdef MULDIV_DIV_EN
              bus.op[1] && (bus.src_b == '0): begin
                state_d = DONE;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                lo_d    = '1;
                hi_d    = bus.src_a;
              end
              default: begin
                state_d = DIV;
                m_d     = b_mag;
                q_d     = a_mag;
              end
`else
              default: begin
                state_d = DONE;
                done_d  = 1'b1;
              end
`endif
            endcase
          end
        end
        MUL: begin
          acc_d = prod[2*WIDTH-1:WIDTH];
          q_d   = prod[WIDTH-1:0];
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
            hi_d    = prod_fix[2*WIDTH-1:WIDTH];
            lo_d    = prod_fix[WIDTH-1:0];
          end
        end
        DIV: begin
`ifdef MULDIV_DIV_EN
          acc_d = rem;
          q_d   = quo;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == MUL) || (state_d == DIV);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      sgn_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, queue scoreboard checked on done.
// Divide expectations follow whether MULDIV_DIV_EN is defined.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  int           n_pass = 0;
  int           n_tot  = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  // monitor: every done must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL spurious_done: got done=1 want done=0");
        end else begin
          e = exp_q.pop_front();
          chk("sb_hi", 64'(bus.hi), 64'(e.hi));
          chk("sb_lo", 64'(bus.lo), 64'(e.lo));
          chk("sb_dbz", 64'(bus.div_by_zero), 64'(e.dbz));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic ed,
                       input bit push);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = ed;
    if (push) exp_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.src_a = ~a;
    bus.src_b = b + 32'd1;
  endtask

  task automatic wait_done(input string nm, input int lat, input bit poke,
                           input bit chk_l1, input logic [W-1:0] l1);
    int n  = 0;
    int nb = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (chk_l1 && n == 1)
        chk({nm, "_wr_at_start"}, 64'(bus.lo), 64'(l1));
      if (bus.done) break;
      if (bus.busy) nb++;
      if (poke && n == 5) begin
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'hA5A5A5A5;
      end else if (poke && n == 6) begin
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
      end
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_busy"}, 64'(nb), 64'(lat - 1));
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int lat, input bit poke);
    issue(op, a, b, eh, el, ed, 1'b1);
    wait_done(nm, lat, poke, 1'b0, '0);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    int seen;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.flush   = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // MTHI / MTLO in IDLE
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h11112222;
    @(posedge clk);
    #1;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h33334444;
    @(posedge clk);
    #1;
    bus.wr_lo = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h11112222);
    chk("mtlo", 64'(bus.lo), 64'h33334444);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1);

    // write coincident with accepted start, then overwritten by result
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h0000DEAD;
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
    wait_done("multu_wr", 33, 1'b0, 1'b1, 32'h0000DEAD);
    cur_hi = 32'd0;
    cur_lo = 32'd6;

`ifdef MULDIV_DIV_EN
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_op("div_min", 2'b11, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
    run_op("divu_zero", 2'b10, 32'd5, 32'd0,
           32'd5, 32'hFFFFFFFF, 1'b1, 1, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 33, 1'b0);
    run_op("div_pos_neg", 2'b11, 32'd7, 32'hFFFFFFFE,
           32'd1, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
`else
    run_op("divu_nodiv", 2'b10, 32'd9, 32'd3,
           cur_hi, cur_lo, 1'b0, 1, 1'b0);
    run_op("div_nodiv_zero", 2'b11, 32'h80000000, 32'd0,
           cur_hi, cur_lo, 1'b0, 1, 1'b0);
`endif

    // flush on cycle 10 of MULTU 3*4, with an ignored MTLO while busy
    issue(2'b00, 32'd3, 32'd4, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h00001234;
    @(posedge clk);
    #1;
    bus.wr_lo = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_c10", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c11", 64'(bus.busy), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'(cur_hi));
    chk("flush_lo", 64'(bus.lo), 64'(cur_lo));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // reset in cycle 5 of an in-flight operation
`ifdef MULDIV_DIV_EN
    issue(2'b10, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
`else
    issue(2'b00, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
`endif
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("arst_nodone", 64'(seen), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
